// File: rtl/sd_content_overlay_if.sv
// Signal bundle between the fake-SD engine, the overlay and the image ROM.
// The master side is the engine plus the ROM. The slave side is the overlay.
interface sd_content_overlay_if #(
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 16,
    parameter int ENTRIES = 16
);
    localparam int UW = $clog2(ENTRIES + 1);

    logic              rdreq;
    logic [ADDR_W-1:0] rdaddr;
    logic              rdvalid;
    logic [DATA_W-1:0] rddata;

    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    logic              wrreq;
    logic [ADDR_W-1:0] wraddr;
    logic [DATA_W-1:0] wrdata;
    logic              clr;

    logic [UW-1:0]     used;
    logic              full;
    logic              wr_drop;
    logic              ev_valid;
    logic [ADDR_W-1:0] ev_addr;
    logic [DATA_W-1:0] ev_data;

    modport master (
        output rdreq, rdaddr, rom_data, wrreq, wraddr, wrdata, clr,
        input  rdvalid, rddata, rom_req, rom_addr,
        input  used, full, wr_drop, ev_valid, ev_addr, ev_data
    );

    modport slave (
        input  rdreq, rdaddr, rom_data, wrreq, wraddr, wrdata, clr,
        output rdvalid, rddata, rom_req, rom_addr,
        output used, full, wr_drop, ev_valid, ev_addr, ev_data
    );
endinterface

// File: rtl/sd_content_overlay.sv
// Writable overlay in front of the read-only SD image ROM.
// Reads go to the ROM. Any word the host has written replaces the ROM word.
// Written words are held in a small fully-associative store.
// The read pipe has a latency of two cycles. The CAM compare happens in the same cycle that
// ROM data is valid, so a read sees every write committed at or before its own request edge.
module sd_content_overlay #(
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 16,
    parameter int ENTRIES = 16,
    parameter int REPLACE = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    sd_content_overlay_if.slave   bus
);
    localparam int IW = $clog2(ENTRIES);
    localparam int UW = $clog2(ENTRIES + 1);

    logic [ADDR_W-1:0] ent_addr [ENTRIES];
    logic [DATA_W-1:0] ent_data [ENTRIES];
    logic [ENTRIES-1:0] ent_valid;
    logic [UW-1:0]     used_q;
    logic [IW-1:0]     rr_q;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic              rdvalid_q;
    logic [DATA_W-1:0] rddata_q;

    logic              wr_drop_q;
    logic              ev_valid_q;
    logic [ADDR_W-1:0] ev_addr_q;
    logic [DATA_W-1:0] ev_data_q;

    logic              wr_hit;
    logic [IW-1:0]     wr_hit_idx;
    logic              free_any;
    logic [IW-1:0]     free_idx;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_hit_data;

    assign bus.rom_req  = bus.rdreq;
    assign bus.rom_addr = bus.rdaddr;

    assign bus.rdvalid  = rdvalid_q;
    assign bus.rddata   = rddata_q;
    assign bus.used     = used_q;
    assign bus.full     = (used_q == UW'(ENTRIES));
    assign bus.wr_drop  = wr_drop_q;
    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_addr  = ev_addr_q;
    assign bus.ev_data  = ev_data_q;

    // Write-side lookup: matching slot, and the lowest free slot (the loop runs downward so the lowest wins)
    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        free_any   = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_addr[i] == bus.wraddr)) begin
                wr_hit     = 1'b1;
                wr_hit_idx = IW'(i);
            end
            if (!ent_valid[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Read-side CAM compare on the stage-1 address. At most one slot matches, so OR-ing the data is a mux.
    always_comb begin
        rd_hit      = 1'b0;
        rd_hit_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_valid[i] && (ent_addr[i] == s1_addr)) begin
                rd_hit      = 1'b1;
                rd_hit_data = rd_hit_data | ent_data[i];
            end
        end
    end

    // Overlay store update: clr takes priority, then hit, then allocate, then evict or drop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_valid  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
            used_q     <= '0;
            rr_q       <= '0;
            wr_drop_q  <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_addr_q  <= '0;
            ev_data_q  <= '0;
        end else begin
            wr_drop_q  <= 1'b0;
            ev_valid_q <= 1'b0;
            if (bus.clr) begin
                ent_valid <= '0;
                used_q    <= '0;
                rr_q      <= '0;
            end else if (bus.wrreq) begin
                if (wr_hit) begin
                    ent_data[wr_hit_idx] <= bus.wrdata;
                end else if (free_any) begin
                    ent_valid[free_idx] <= 1'b1;
                    ent_addr[free_idx]  <= bus.wraddr;
                    ent_data[free_idx]  <= bus.wrdata;
                    used_q              <= used_q + UW'(1);
                end else if (REPLACE != 0) begin
                    ev_valid_q     <= 1'b1;
                    ev_addr_q      <= ent_addr[rr_q];
                    ev_data_q      <= ent_data[rr_q];
                    ent_addr[rr_q] <= bus.wraddr;
                    ent_data[rr_q] <= bus.wrdata;
                    rr_q           <= (rr_q == IW'(ENTRIES - 1)) ? '0 : rr_q + IW'(1);
                end else begin
                    wr_drop_q <= 1'b1;
                end
            end
        end
    end

    // Two-stage read pipe. Stage 1 captures the request. Stage 2 chooses the overlay word or the ROM word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            rdvalid_q <= 1'b0;
            rddata_q  <= '0;
        end else begin
            s1_valid  <= bus.rdreq;
            s1_addr   <= bus.rdaddr;
            rdvalid_q <= s1_valid;
            if (s1_valid) begin
                rddata_q <= rd_hit ? rd_hit_data : bus.rom_data;
            end
        end
    end
endmodule
